// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the multicycle multiply/divide unit:
//   OP_W    : width of the operation code
//   op_t    : operation codes sampled with start
//   state_t : sequencer states (IDLE -> CALC -> FIX -> IDLE)
// ---------------------------------------------------------------------------
package mult_div_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MADDU = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One combinational radix-2 iteration on the {acc, q} register pair.
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : upper working word (partial product high / partial remainder)
//   q        : lower working word (multiplier bits / dividend-quotient bits)
//   m        : multiplicand or divisor magnitude
//   acc_next : updated upper word
//   q_next   : updated lower word
// Multiply consumes the multiplier LSB first and shifts the pair right, so
// after WIDTH steps {acc, q} holds the full product. Divide shifts the pair
// left, trial-subtracts the divisor and shifts a quotient bit into q, so after
// WIDTH steps acc holds the remainder and q the quotient.
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] add_sel;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, m};
        add_sel = q[0] ? sum : {1'b0, acc};
        rem     = {acc, q[WIDTH-1]};
        diff    = rem - {1'b0, m};
        if (is_div) begin
            // acc < m always holds, so rem < 2m and bit WIDTH of diff is a
            // clean borrow flag: set exactly when rem < m.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = add_sel[WIDTH:1];
            q_next   = {add_sel[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multicycle multiply/divide unit with architectural HI/LO registers.
// Ports:
//   Clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, clears all state
//   start     : request, sampled only in IDLE
//   op        : operation (see mult_div_pkg::op_t), sampled with start
//   oper_A    : multiplicand / dividend / MTHI-MTLO source
//   oper_B    : multiplier / divisor
//   busy      : high while an operation is in flight
//   done      : one-cycle pulse, HI/LO hold the new values in that cycle
//   div_zero  : sticky divide-by-zero flag, cleared by the next accepted start
//   HI, LO    : high product word / remainder, low product word / quotient
// Optional feature: define MULT_DIV_MADD_EN to enable MADD/MADDU
// (multiply-accumulate into {HI,LO}); otherwise those starts are ignored.
// Operations run on magnitudes; signs are reapplied in FIX.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic             is_div_reg, is_div_next;
    logic             madd_reg, madd_next;
    logic             neg_res_reg, neg_res_next;
    logic             neg_rem_reg, neg_rem_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             done_reg, done_next;
    logic             div_zero_reg, div_zero_next;

    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_q;

    op_t                op_in;
    logic               is_signed;
    logic               is_div_op;
    logic               is_madd_op;
    logic               a_neg;
    logic               b_neg;
    logic               arith_op;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] prod_sum;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .q        (q_reg),
        .m        (m_reg),
        .acc_next (step_acc),
        .q_next   (step_q)
    );

    assign op_in = op_t'(op);

    // Operation decode for the request in front of the unit.
    always_comb begin
        is_signed  = (op_in == OP_MULT) || (op_in == OP_DIV) || (op_in == OP_MADD);
        is_div_op  = (op_in == OP_DIV) || (op_in == OP_DIVU);
        is_madd_op = (op_in == OP_MADD) || (op_in == OP_MADDU);
`ifdef MULT_DIV_MADD_EN
        arith_op   = (op_in == OP_MULT) || (op_in == OP_MULTU) || is_div_op || is_madd_op;
`else
        arith_op   = (op_in == OP_MULT) || (op_in == OP_MULTU) || is_div_op;
`endif
        a_neg      = is_signed && oper_A[WIDTH-1];
        b_neg      = is_signed && oper_B[WIDTH-1];
    end

    // Result correction: negate the full product, then optionally accumulate.
    always_comb begin
        prod     = {acc_reg, q_reg};
        prod_fix = neg_res_reg ? (~prod + 1'b1) : prod;
        prod_sum = {hi_reg, lo_reg} + prod_fix;
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_next      = acc_reg;
        q_next        = q_reg;
        m_next        = m_reg;
        is_div_next   = is_div_reg;
        madd_next     = madd_reg;
        neg_res_next  = neg_res_reg;
        neg_rem_next  = neg_rem_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        done_next     = 1'b0;
        div_zero_next = div_zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (arith_op) begin
                        if (is_div_op && (oper_B == '0)) begin
                            // Divide by zero finishes immediately, HI/LO untouched.
                            div_zero_next = 1'b1;
                            done_next     = 1'b1;
                        end else begin
                            div_zero_next = 1'b0;
                            acc_next      = '0;
                            q_next        = a_neg ? (~oper_A + 1'b1) : oper_A;
                            m_next        = b_neg ? (~oper_B + 1'b1) : oper_B;
                            neg_res_next  = a_neg ^ b_neg;
                            neg_rem_next  = a_neg;
                            is_div_next   = is_div_op;
                            madd_next     = is_madd_op;
                            cnt_next      = CNT_W'(WIDTH);
                            state_next    = CALC;
                        end
                    end else if (op_in == OP_MTHI) begin
                        hi_next       = oper_A;
                        done_next     = 1'b1;
                        div_zero_next = 1'b0;
                    end else if (op_in == OP_MTLO) begin
                        lo_next       = oper_A;
                        done_next     = 1'b1;
                        div_zero_next = 1'b0;
                    end
                end
            end

            CALC: begin
                acc_next = step_acc;
                q_next   = step_q;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                if (is_div_reg) begin
                    lo_next = neg_res_reg ? (~q_reg + 1'b1) : q_reg;
                    hi_next = neg_rem_reg ? (~acc_reg + 1'b1) : acc_reg;
                end else if (madd_reg) begin
                    {hi_next, lo_next} = prod_sum;
                end else begin
                    {hi_next, lo_next} = prod_fix;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            is_div_reg   <= 1'b0;
            madd_reg     <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_reg      <= acc_next;
            q_reg        <= q_next;
            m_reg        <= m_next;
            is_div_reg   <= is_div_next;
            madd_reg     <= madd_next;
            neg_res_reg  <= neg_res_next;
            neg_rem_reg  <= neg_rem_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            done_reg     <= done_next;
            div_zero_reg <= div_zero_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign HI       = hi_reg;
    assign LO       = lo_reg;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide unit with architectural HI/LO registers, for the multicycle MIPS datapath.
- Supports signed and unsigned MULT/DIV plus MTHI/MTLO.
- Sits beside the ALS block; takes operands from the A/B registers and is sequenced by Control through a start/busy/done handshake.
- HI/LO feed the register-file write-data mux (MFHI/MFLO path).

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH each; must be even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation, sampled with start: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
- oper_A  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- oper_B  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new values in this cycle.
- div_zero  out  1  sticky; set by DIV/DIVU with oper_B==0; cleared by the next accepted start.
- HI  out  WIDTH  high product word / remainder.
- LO  out  WIDTH  low product word / quotient.

Behaviour:
- Reset: HI=0, LO=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU (divisor nonzero):
  - Latch magnitudes of oper_A/oper_B; for signed ops, latch the result-sign and remainder-sign flags.
  - Load counter=WIDTH, set busy=1, go to CALC.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
  - Counter decrements; at counter==1 go to FIX.
  - Exactly WIDTH cycles are spent in CALC.
- FIX:
  - Apply sign correction: two's-complement negate of the 2*WIDTH product, or of quotient/remainder independently.
  - Write HI/LO, busy=0, done=1, go to IDLE.
- Latency: start edge at cycle 0 -> done=1 and HI/LO valid after edge WIDTH+1 (34 cycles for WIDTH=32).
- Arithmetic:
  - Product is full 2*WIDTH bits, {HI,LO}.
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1 gives LO=MIN, HI=0, with no flag.
- Divide by zero:
  - No CALC phase; div_zero=1 and done=1 on the edge after start.
  - HI/LO are unchanged; busy stays 0.
- MTHI/MTLO in IDLE:
  - HI (or LO) <= oper_A on the start edge, done=1 in the following cycle, busy never rises.
- Ignored starts:
  - start while busy is ignored; the in-flight operation is unaffected.
  - Operand changes after the start edge have no effect.
- done is registered and is exactly one cycle wide; start may be reasserted in the cycle done=1 and is accepted.
- HI/LO change only on done edges (or reset); they are never partially updated mid-operation.
- reset asserted mid-operation: immediate return to the reset values; no done.

Optional Feature:
- Macro MULT_DIV_MADD_EN.
- Defined:
  - op 110/111 perform a signed/unsigned multiply and add the 2*WIDTH product into {HI,LO} during FIX.
  - Addition is modulo 2^(2*WIDTH); latency is the same as MULT.
- Undefined:
  - op 110/111 with start are ignored: no busy, no done, HI/LO unchanged.

Decomposition:
- Package mult_div_pkg:
  - op_t enum (8 codes above).
  - state_t enum {IDLE, CALC, FIX}.
  - OP_W=3 constant.
- One sub-module, muldiv_step: combinational single iteration (multiply add-shift or divide subtract-shift) on {acc, operand} for parametric WIDTH.
- FSM, counter, sign handling and HI/LO live in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1-33.
- MULT -7 * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> div_zero=1 and done on the next edge, HI/LO keep the prior values; next MULTU 2*3 clears div_zero, LO=6.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
- Start MULTU 5*5, pulse start with DIVU in cycle 10, drop reset in cycle 20:
  - Second start ignored.
  - After reset: HI=LO=0, busy=0, no done.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> done each following cycle, busy stays 0. With MULT_DIV_MADD_EN, MADDU 2*3 then gives LO=0x567E, HI=0x1234.
